// File: rtl/onehot_capture_encoder.sv
// Captures qualified one-hot decoder words, encodes them to a 3-bit index and
// queues them in a first-word-fall-through FIFO; malformed words are counted.
module onehot_capture_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               y_in,
    input  logic                     in_valid,
    output logic [2:0]               idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     bad_code,
    output logic [7:0]               bad_cnt,
    output logic                     overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          one_hot;
    logic          good;
    logic          bad;
    logic          full;
    logic          pop;
    logic          push;
    logic [2:0]    enc;

    always_comb begin
        // x & (x-1) clears the lowest set bit, so zero means at most one bit set
        one_hot = (y_in != '0) && ((y_in & (y_in - 8'd1)) == '0);
        enc     = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (y_in[k[2:0]]) enc = k[2:0];
        end
        good = in_valid && one_hot;
        bad  = in_valid && !one_hot;
        full = (level == LVL_W'(DEPTH));
        pop  = out_valid && out_ready;
        push = good && (!full || pop);
    end

    assign out_valid = (level != '0);
    assign idx       = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            bad_code <= 1'b0;
            bad_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            bad_code <= bad;
            if (bad && (bad_cnt != '1)) bad_cnt <= bad_cnt + 8'd1;
            if (good && !push) overflow <= 1'b1;
        end
    end

endmodule

// File: doc/onehot_capture_encoder.md
ONEHOT_CAPTURE_ENCODER -- requirements
Module: onehot_capture_encoder

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter DEPTH, default 4, SHALL set FIFO entries; legal values are powers of two from 2 to 16.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the synchronous active-high reset.
REQ-005 Port y_in, input, 8, SHALL carry the 8-bit decoder output word; it is expected to be one-hot.
REQ-006 Port in_valid, input, 1, SHALL qualify y_in for the current cycle.
REQ-007 Port idx, output, 3, SHALL present the encoded index at the FIFO head.
REQ-008 Port out_valid, output, 1, SHALL be high when idx holds a valid entry.
REQ-009 Port out_ready, input, 1, SHALL accept the head entry when high with out_valid.
REQ-010 Port level, output, $clog2(DEPTH)+1, SHALL report the current FIFO occupancy.
REQ-011 Port bad_code, output, 1, SHALL be a one-cycle pulse flagging a rejected non-one-hot input.
REQ-012 Port bad_cnt, output, 8, SHALL count rejected inputs and saturate at 255.
REQ-013 Port overflow, output, 1, SHALL be a sticky flag for a valid code dropped because the FIFO was full.

Function
REQ-014 Input check:
- in_valid=1 and popcount(y_in)==1: the input is a good code.
- in_valid=1 and popcount(y_in)==0 or >=2: the input is a bad code.
- in_valid=0: y_in is ignored.
REQ-015 Encoding: a good code with bit k set SHALL encode to idx value k (e.g. 8'b0010_0000 -> 3'd5).
REQ-016 Good code handling:
- Push the encoded index when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Otherwise drop the code and set overflow.
REQ-017 Bad code handling:
- Push nothing.
- Assert bad_code for exactly the next cycle.
- Increment bad_cnt by 1, holding at 8'd255.
REQ-018 Output timing: the FIFO SHALL be first-word-fall-through.
- out_valid = (level != 0).
- idx = head entry; idx = 3'd0 when empty.
REQ-019 Latency: a push into an empty FIFO SHALL raise out_valid and present idx on the cycle after the accepting edge (1-cycle latency).
REQ-020 Pop: an edge with out_valid && out_ready SHALL pop the head; the next entry, if any, appears on the following cycle.
REQ-021 Hold: while out_valid=1 and out_ready=0, idx and out_valid SHALL hold stable.
REQ-022 Simultaneous push and pop with 0 < level < DEPTH: level is unchanged and order is preserved.
REQ-023 Simultaneous push and pop at level==DEPTH: both occur, level stays DEPTH, overflow is not set.
REQ-024 Push attempt when empty with out_ready=1: no pop occurs, since out_valid was 0; level becomes 1.
REQ-025 Pointers SHALL wrap modulo DEPTH with no loss or duplication of entries across the wrap.
REQ-026 Level SHALL never exceed DEPTH and never go below 0.
REQ-027 overflow SHALL stay set until reset; bad_cnt SHALL clear only on reset.
REQ-028 No combinational path SHALL exist from y_in or in_valid to any output.

Reset
REQ-029 Reset values while rst is high at an edge:
- level=0, out_valid=0, idx=3'd0.
- bad_code=0, bad_cnt=8'd0, overflow=0.
- Read and write pointers = 0.
REQ-030 Reset SHALL take priority over a simultaneous push, pop or bad code in the same cycle; FIFO contents are discarded.
REQ-031 The first input accepted after rst deasserts SHALL behave as on an empty FIFO (REQ-019).

Verification
REQ-032 Sweep: apply y_in=1<<k for k=0..7, one per cycle, out_ready=1 -> idx sequence 0,1,...,7, each 1 cycle after its input; bad_cnt=0.
REQ-033 Bad codes: y_in=8'h00, then 8'h03, then 8'hFF with in_valid=1 -> three bad_code pulses; bad_cnt=3; level stays 0.
REQ-034 Fill and overflow: out_ready=0, push 5 good codes (idx 2,4,6,1,3) with DEPTH=4 -> level=4, overflow=1; drain yields 2,4,6,1.
REQ-035 Full push and pop: level=4, out_ready=1, and a push of 8'h80 in the same cycle -> level stays 4, overflow stays 0, and 7 emerges last.
REQ-036 Reset mid-operation: level=3 and bad_cnt=5, assert rst for 1 cycle -> all outputs at reset values on the next cycle, and the next push of 8'h10 gives idx=4 one cycle later.
REQ-037 Saturation: 260 consecutive bad codes -> bad_cnt=255, bad_code pulses every cycle, no wrap of bad_cnt.
